// File: rtl/adder_pkg.sv
// Shared types and helpers for the chunked, pipelined adder/subtractor.
// Latency: none (types only).
// Backpressure: none (types only).
package adder_pkg;

  // Widest datapath the stage record can carry; narrower instances use the low bits.
  localparam int MAX_W = 64;

  function automatic int stages(input int width, input int chunk);
    return width / chunk;
  endfunction

  typedef struct packed {
    logic             vld;
    logic             carry;
    logic [MAX_W-1:0] res;
    logic [MAX_W-1:0] pa;
    logic [MAX_W-1:0] pb;
  } stage_t;

endpackage

// File: rtl/add_stage.sv
// One CHUNK-bit ripple slice plus its pipeline register.
// Latency: 1 cycle (registered on advance).
// Backpressure: holds its contents while adv is low; a bubble loads when src.vld is low.
module add_stage
  import adder_pkg::*;
#(
  parameter int CHUNK = 4,
  parameter int K     = 0
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   adv,
  input  stage_t src,
  output stage_t q
);

  logic [CHUNK:0] sum;

  assign sum = {1'b0, src.pa[K*CHUNK +: CHUNK]}
             + {1'b0, src.pb[K*CHUNK +: CHUNK]}
             + {{CHUNK{1'b0}}, src.carry};

  // Upper operand chunks ride along unchanged so they stay aligned with their carry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (adv) begin
      q                       <= src;
      q.res[K*CHUNK +: CHUNK] <= sum[CHUNK-1:0];
      q.carry                 <= sum[CHUNK];
    end
  end

endmodule

// File: rtl/pipe_adder.sv
// Pipelined two's-complement add/sub, one CHUNK-bit slice per stage.
// Latency: WIDTH/CHUNK cycles from accept to out_valid; 1 op/cycle sustained.
// Backpressure: combinational ready chain from out_ready; holds up to WIDTH/CHUNK beats.
module pipe_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = stages(WIDTH, CHUNK);

  if ((CHUNK < 1) || (WIDTH % CHUNK != 0) || (WIDTH > MAX_W)) begin : g_bad_cfg
    $error("pipe_adder: WIDTH must be a multiple of CHUNK and no wider than MAX_W");
  end

  stage_t             head;
  stage_t             q [STAGES];
  logic [STAGES-1:0]  adv;
  logic [WIDTH-1:0]   b_eff;

  // Subtraction is a + ~b + 1.
  assign b_eff = sub ? ~b : b;

  always_comb begin
    head                = '0;
    head.vld            = in_valid;
    head.carry          = sub ? 1'b1 : cin;
    head.pa[WIDTH-1:0]  = a;
    head.pb[WIDTH-1:0]  = b_eff;
  end

  // A stage may load when it is empty or its successor is moving on.
  always_comb begin
    adv             = '0;
    adv[STAGES-1]   = !q[STAGES-1].vld || out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      adv[k] = !q[k].vld || adv[k+1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stage_t src;
    if (k == 0) begin : g_head
      assign src = head;
    end else begin : g_chain
      assign src = q[k-1];
    end

    add_stage #(
      .CHUNK (CHUNK),
      .K     (k)
    ) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .adv   (adv[k]),
      .src   (src),
      .q     (q[k])
    );
  end

  assign in_ready  = adv[0];
  assign out_valid = q[STAGES-1].vld;
  assign s         = q[STAGES-1].res[WIDTH-1:0];
  assign cout      = q[STAGES-1].carry;
  // Carry into the MSB is recovered from the MSB's own sum bit.
  assign ovf       = q[STAGES-1].pa[WIDTH-1] ^ q[STAGES-1].pb[WIDTH-1]
                   ^ q[STAGES-1].res[WIDTH-1] ^ q[STAGES-1].carry;

endmodule

// File: tb/tb_pipe_adder.sv
// Self-checking bench for pipe_adder (WIDTH=8, CHUNK=4) against an arithmetic model.
module tb_pipe_adder;

  localparam int WIDTH  = 8;
  localparam int CHUNK  = 4;
  localparam int STAGES = WIDTH / CHUNK;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;

  pipe_adder #(
    .WIDTH (WIDTH),
    .CHUNK (CHUNK)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] s;
    logic       cout;
    logic       ovf;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   n_in     = 0;
  int   n_out    = 0;
  int   last_lat = -1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views of the operands.
  function automatic exp_t model(input int av, input int bv, input int ci, input int sm, input int at);
    exp_t e;
    int   sa, sbv, r, sr;
    sa  = (av > 127) ? av - 256 : av;
    sbv = (bv > 127) ? bv - 256 : bv;
    if (sm != 0) begin
      r      = av - bv;
      sr     = sa - sbv;
      e.cout = (av >= bv);
    end else begin
      r      = av + bv + ci;
      sr     = sa + sbv + ci;
      e.cout = (r > 255);
    end
    r     = (r + 512) % 256;
    e.s   = r[7:0];
    e.ovf = (sr > 127) || (sr < -128);
    e.cyc = at;
    return e;
  endfunction

  // One clock: observe both handshakes at negedge, then step past the rising edge.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", {31'd0, out_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("result", {22'd0, cout, ovf, s}, {22'd0, e.cout, e.ovf, e.s});
        last_lat = cyc - e.cyc;
        n_out++;
      end
    end
    if (in_valid && in_ready) begin
      exp_q.push_back(model(int'(a), int'(b), int'(cin), int'(sub), cyc));
      n_in++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_out(input int target, input string tag);
    for (int i = 0; i < 60 && n_out < target; i++) cycle();
    check(tag, n_out, target);
  endtask

  task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic ci,
                        input logic sm, input string tag);
    int tgt_in;
    a = av; b = bv; cin = ci; sub = sm; in_valid = 1'b1;
    tgt_in = n_in + 1;
    for (int i = 0; i < 20 && n_in < tgt_in; i++) cycle();
    in_valid = 1'b0;
    check({tag, "_accept"}, n_in, tgt_in);
    wait_out(n_out + exp_q.size(), {tag, "_drain"});
    check({tag, "_latency"}, last_lat, STAGES);
  endtask

  task automatic rand_ops();
    a   = 8'($urandom_range(0, 255));
    b   = 8'($urandom_range(0, 255));
    cin = 1'($urandom_range(0, 1));
    sub = 1'($urandom_range(0, 1));
  endtask

  initial begin
    #60000;
    $display("FAIL watchdog global timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base_in, base_out, tgt, prev;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    cycle(); cycle();
    rst_n = 1'b1;

    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_s", {24'd0, s}, 32'd0);
    check("reset_cout_ovf", {30'd0, cout, ovf}, 32'd0);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);

    run_op(8'h0F, 8'h01, 1'b0, 1'b0, "add_0f_01");
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, "add_ff_01");
    run_op(8'h7F, 8'h01, 1'b0, 1'b0, "add_7f_01");
    run_op(8'h00, 8'h00, 1'b1, 1'b0, "add_cin");
    run_op(8'h05, 8'h07, 1'b0, 1'b1, "sub_05_07");
    run_op(8'h80, 8'h01, 1'b0, 1'b1, "sub_80_01");
    run_op(8'h10, 8'h10, 1'b1, 1'b1, "sub_cin_ignored");

    // Backpressure: fill the pipe with the consumer stalled.
    base_in = n_in; base_out = n_out;
    out_ready = 1'b0; in_valid = 1'b1;
    a = 8'h12; b = 8'h34; cin = 1'b0; sub = 1'b0; cycle();
    a = 8'h9C; b = 8'h21; cin = 1'b0; sub = 1'b1; cycle();
    a = 8'hF0; b = 8'h20; cin = 1'b1; sub = 1'b0; cycle();
    check("bp_accepted_two", n_in, base_in + 2);
    check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    check("bp_out_valid", {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      check("bp_hold", {22'd0, cout, ovf, s}, {22'd0, exp_q[0].cout, exp_q[0].ovf, exp_q[0].s});
      cycle();
    end
    check("bp_still_two", n_in, base_in + 2);
    out_ready = 1'b1;
    #1;
    check("bp_ready_full_drain", {31'd0, in_ready}, 32'd1);
    cycle();
    check("bp_accept_and_drain", n_in, base_in + 3);
    in_valid = 1'b0;
    wait_out(base_out + 3, "bp_all_out");

    // Back-to-back with an always-ready consumer: no output gaps once flowing.
    base_out = n_out; tgt = n_in + 16;
    out_ready = 1'b1; in_valid = 1'b1; rand_ops();
    for (int i = 0; i < 100 && n_in < tgt; i++) begin
      prev = n_in;
      cycle();
      if (n_in != prev) rand_ops();
      if (n_out > base_out) check("no_gap", {31'd0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    check("b2b_accept", n_in, tgt);
    wait_out(n_out + exp_q.size(), "b2b_drain");

    // Random consumer stalls over 32 beats.
    tgt = n_in + 32;
    in_valid = 1'b1; rand_ops();
    for (int i = 0; i < 400 && n_in < tgt; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      prev = n_in;
      cycle();
      if (n_in != prev) rand_ops();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("rand_accept", n_in, tgt);
    wait_out(n_out + exp_q.size(), "rand_drain");
    check("rand_queue_empty", exp_q.size(), 0);

    // Reset with two beats in flight.
    out_ready = 1'b0; in_valid = 1'b1;
    a = 8'hAA; b = 8'h55; cin = 1'b1; sub = 1'b0; cycle();
    a = 8'h3C; b = 8'hC3; cin = 1'b0; sub = 1'b1; cycle();
    in_valid = 1'b0;
    check("rst_inflight_valid", {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    exp_q.delete();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_s", {24'd0, s}, 32'd0);
    check("rst_cout_ovf", {30'd0, cout, ovf}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("rst_no_stale", {31'd0, out_valid}, 32'd0);
    end
    run_op(8'h21, 8'h43, 1'b0, 1'b0, "post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
